scan_chain_ctl: RTL
===================

# scan_chain_ctl

Parametrised scan capture/shift/update cell for the design-for-test chain. It supersedes the single-beat scan register with three additions:
- an explicit capture → shift → update sequence;
- a beat counter that handles any ratio of data width to scan width;
- completion and error status.

It sits between a functional datapath and the scan chain. `D_OUT` passes `D_IN` through unless an update override is active.

## Interface
**Parameters**
- `width`, 8: functional data width W (≥1).
- `SCAN_WIDTH`, 1: bits shifted per beat S (1 ≤ S ≤ W).

**Ports**
- `CLK` in 1: sole clock. All logic is on its rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `D_IN` in W: functional data.
- `D_OUT` out W: functional output.
- `SCAN_IN` in S: scan data in.
- `SCAN_OUT` out S: scan data out.
- `CAPTURE` in 1: load chain from `D_IN`.
- `SHIFT_EN` in 1: perform one shift beat.
- `UPDATE` in 1: commit chain to shadow.
- `OVERRIDE` in 1: drive `D_OUT` from shadow (update build only).
- `SHIFT_DONE` out 1: N beats completed since capture.
- `BEAT_CNT` out `$clog2(N+1)`: beats taken.
- `ERR` out 1: sticky protocol error; cleared by `CAPTURE` or reset.

## Operation
- N = ceil(W/S); chain register L = N·S bits.
- Data occupies `chain[W-1:0]`; the pad bits `chain[L-1:W]` capture as 0.
- `SCAN_OUT = chain[L-1:L-S]`, registered.
- A shift is `chain <= {chain[L-S-1:0], SCAN_IN}`. The first beat in ends up in the top slot after N beats.
- State machine:
  - IDLE: `CAPTURE` → LOADED.
  - LOADED: `SHIFT_EN` → SHIFTING, or straight to DONE if N=1.
  - SHIFTING: each `SHIFT_EN` beat increments `BEAT_CNT`; the Nth beat → DONE.
  - DONE: `UPDATE` → IDLE.
- `CAPTURE` in any state:
  - reloads the chain, zeroes `BEAT_CNT`, clears `ERR` → LOADED;
  - wins over a simultaneous `SHIFT_EN` or `UPDATE`.
- `SHIFT_EN` in DONE: the chain does not shift, `ERR` is set, `BEAT_CNT` saturates at N.
- `SHIFT_EN` in IDLE: ignored, `ERR` is set.
- `UPDATE` outside DONE: ignored, `ERR` is set.
- `UPDATE` together with `SHIFT_EN` in DONE: update performed, `ERR` is set.
- `SHIFT_EN` stalls are legal. The chain holds whenever no beat occurs.
- `SHIFT_DONE` is high exactly in DONE.

## Timing
- Reset values: chain 0, shadow 0, state IDLE, `SCAN_OUT` 0, `BEAT_CNT` 0, `SHIFT_DONE` 0, `ERR` 0, `D_OUT` equal to `D_IN`.
- `CAPTURE` at edge t samples `D_IN`. `SCAN_OUT` shows the captured top slot from t+1.
- Each beat at edge t presents the next slot on `SCAN_OUT` at t+1. `BEAT_CNT` and `SHIFT_DONE` update at t+1.
- `UPDATE` at edge t loads the shadow. `D_OUT` reflects it from t+1 if `OVERRIDE`=1.
- `D_OUT` is combinational from `D_IN`, shadow and `OVERRIDE`, with zero latency.
- Reset mid-shift returns every register to its reset value on that edge; partial chain contents are lost.

## Configuration
Macro `SCAN_CHAIN_UPDATE_EN`.

**Defined**
- Shadow register, `UPDATE` commit and `OVERRIDE` mux are present.
- `D_OUT = OVERRIDE ? shadow : D_IN`.

**Undefined**
- No shadow register; `D_OUT = D_IN` always.
- `OVERRIDE` is ignored.
- `UPDATE` still moves DONE → IDLE and applies the same `ERR` rules.

## Structure
- Shared package `scan_pkg` holds:
  - the state enum (IDLE, LOADED, SHIFTING, DONE);
  - function `scan_beats(W,S)` returning ceil(W/S).
- One sub-module, `scan_beat_counter`: saturating counter with terminal-count output, parametrised by N.
- The FSM, chain and shadow stay in the top module.

## Test plan
All scenarios use W=8, S=3, N=3, L=9.
- Reset with `RST_N`=0 for 2 cycles → all status 0, `SCAN_OUT`=3'b000, `D_OUT` follows `D_IN`=8'h3C.
- `CAPTURE` with `D_IN`=8'hA5, then 3 beats → `SCAN_OUT` reads 3'b010, 3'b100, 3'b101; `SHIFT_DONE`=1 after the 3rd beat, `BEAT_CNT`=3.
- After capture, shift in 3'b001, 3'b010, 3'b011, then `UPDATE` with `OVERRIDE`=1 → `D_OUT`=8'h53 (update build); `D_OUT`=`D_IN` (non-update build).
- Beats with `SHIFT_EN` gaps of 0, 2 and 5 idle cycles → same outputs as the gap-free case; chain stable during gaps.
- 4th `SHIFT_EN` in DONE → chain unchanged, `ERR`=1. Next `CAPTURE` → `ERR`=0, LOADED.
- `UPDATE` in LOADED → `ERR`=1, shadow unchanged. `CAPTURE` with `SHIFT_EN` in the same cycle → capture wins, `BEAT_CNT`=0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan capture/shift/update cell.
// Latency: none (types and constant functions only).
// Backpressure: none.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOADED   = 2'd1,
        SHIFTING = 2'd2,
        DONE     = 2'd3
    } scan_state_t;

    // Number of scan beats needed to move a W-bit word through an S-bit chain.
    function automatic int scan_beats(input int w, input int s);
        return (w + s - 1) / s;
    endfunction

endpackage

// File: rtl/scan_beat_counter.sv
// Saturating beat counter; tc flags the increment that reaches N.
// Latency: cnt updates one cycle after inc; tc is combinational from inc/cnt.
// Backpressure: none, inc is taken whenever asserted (clr wins).
module scan_beat_counter #(
    parameter int N  = 3,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = inc && (cnt == CNT_LAST);

endmodule

// File: rtl/scan_chain_ctl.sv
// Scan capture/shift/update cell; SCAN_CHAIN_UPDATE_EN adds the shadow/override path.
// Latency: SCAN_OUT/status one cycle after the controlling edge; D_OUT combinational.
// Backpressure: SHIFT_EN may stall freely, the chain holds whenever no beat occurs.
module scan_chain_ctl
    import scan_pkg::*;
#(
    parameter int width      = 8,
    parameter int SCAN_WIDTH = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [width-1:0]      D_IN,
    output logic [width-1:0]      D_OUT,
    input  logic [SCAN_WIDTH-1:0] SCAN_IN,
    output logic [SCAN_WIDTH-1:0] SCAN_OUT,
    input  logic                  CAPTURE,
    input  logic                  SHIFT_EN,
    input  logic                  UPDATE,
    input  logic                  OVERRIDE,
    output logic                  SHIFT_DONE,
    output logic [$clog2(scan_beats(width, SCAN_WIDTH) + 1)-1:0] BEAT_CNT,
    output logic                  ERR
);

    localparam int N  = scan_beats(width, SCAN_WIDTH);
    localparam int L  = N * SCAN_WIDTH;
    localparam int CW = $clog2(N + 1);

    scan_state_t  state;
    logic [L-1:0] chain;
    logic [L-1:0] cap_val;
    logic [L-1:0] shift_val;
    logic         beat;
    logic         last_beat;

    // Pad bits above the data word always capture as zero.
    always_comb begin
        cap_val            = '0;
        cap_val[width-1:0] = D_IN;
    end

    generate
        if (N == 1) begin : g_single_beat
            assign shift_val = SCAN_IN;
        end else begin : g_multi_beat
            assign shift_val = {chain[L-SCAN_WIDTH-1:0], SCAN_IN};
        end
    endgenerate

    assign beat = SHIFT_EN && !CAPTURE && ((state == LOADED) || (state == SHIFTING));

    scan_beat_counter #(
        .N  (N),
        .CW (CW)
    ) u_beat_counter (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (CAPTURE),
        .inc   (beat),
        .cnt   (BEAT_CNT),
        .tc    (last_beat)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            chain      <= '0;
            SHIFT_DONE <= 1'b0;
            ERR        <= 1'b0;
        end else if (CAPTURE) begin
            state      <= LOADED;
            chain      <= cap_val;
            SHIFT_DONE <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            if (beat) begin
                chain <= shift_val;
            end
            case (state)
                IDLE: begin
                    if (SHIFT_EN || UPDATE) begin
                        ERR <= 1'b1;
                    end
                end
                LOADED, SHIFTING: begin
                    if (UPDATE) begin
                        ERR <= 1'b1;
                    end
                    if (beat) begin
                        if (last_beat) begin
                            state      <= DONE;
                            SHIFT_DONE <= 1'b1;
                        end else begin
                            state <= SHIFTING;
                        end
                    end
                end
                DONE: begin
                    // Extra beats are refused; the update itself still goes through.
                    if (SHIFT_EN) begin
                        ERR <= 1'b1;
                    end
                    if (UPDATE) begin
                        state      <= IDLE;
                        SHIFT_DONE <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    SHIFT_DONE <= 1'b0;
                end
            endcase
        end
    end

    assign SCAN_OUT = chain[L-1 -: SCAN_WIDTH];

`ifdef SCAN_CHAIN_UPDATE_EN
    logic [width-1:0] shadow;
    logic             commit;

    assign commit = UPDATE && !CAPTURE && (state == DONE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shadow <= '0;
        end else if (commit) begin
            shadow <= chain[width-1:0];
        end
    end

    assign D_OUT = OVERRIDE ? shadow : D_IN;
`else
    logic unused_override;

    assign unused_override = OVERRIDE;
    assign D_OUT           = D_IN;
`endif

endmodule
